// File: rtl/pll_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pll_pkg
// Purpose  : Lock-state encoding and default loop constants shared by the
//            loop filter / DCO and the phase detector bench.
// Revision : 1.0 - initial release
// ============================================================================
package pll_pkg;

  typedef enum logic [0:0] {
    ACQ    = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

  localparam int C_CNT_W        = 16;
  localparam int C_NOMINAL_HALF = 50;
  localparam int C_MIN_HALF     = 10;
  localparam int C_MAX_HALF     = 200;
  localparam int C_KI           = 1;
  localparam int C_KP           = 4;
  localparam int C_LOCK_EDGES   = 16;

endpackage
`default_nettype wire

// File: rtl/dco_counter.sv
`default_nettype none
// ============================================================================
// Module   : dco_counter
// Purpose  : Phase counter of the DCO. Counts clk_i cycles against a limit
//            supplied every cycle and toggles signal_o when the limit is hit.
// Revision : 1.0 - initial release
// ============================================================================
module dco_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             signal_o,
  output logic             toggle_o
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_signal;
  logic [CNT_W:0]   w_cnt_inc;

  // One extra bit keeps cnt+1 exact; a count already past a freshly
  // shortened limit still satisfies >= and toggles at the next edge.
  assign w_cnt_inc = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign toggle_o  = (w_cnt_inc >= {1'b0, limit_i});
  assign signal_o  = r_signal;

  // Advance the phase counter; restart it and flip the output on a toggle.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_cnt    <= '0;
      r_signal <= 1'b0;
    end else if (toggle_o) begin
      r_cnt    <= '0;
      r_signal <= ~r_signal;
    end else begin
      r_cnt    <= w_cnt_inc[CNT_W-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/loop_filter_dco.sv
`default_nettype none
// ============================================================================
// Module   : loop_filter_dco
// Purpose  : PI loop filter driving a counter-based DCO. Holds the integral
//            half-period, the one-shot proportional kick, the lock FSM and
//            the status flags.
// Revision : 1.0 - initial release
// ============================================================================
module loop_filter_dco
  import pll_pkg::*;
#(
  parameter int CNT_W        = C_CNT_W,
  parameter int NOMINAL_HALF = C_NOMINAL_HALF,
  parameter int MIN_HALF     = C_MIN_HALF,
  parameter int MAX_HALF     = C_MAX_HALF,
  parameter int KI           = C_KI,
  parameter int KP           = C_KP,
  parameter int LOCK_EDGES   = C_LOCK_EDGES
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             forwarding_i,
  input  logic             slowing_i,
  output logic             signal_o,
  output logic [CNT_W-1:0] half_period_o,
  output logic             lock_o,
  output logic             sat_o,
  output logic             conflict_o
);

  localparam int Q_W = $clog2(LOCK_EDGES + 1);

  localparam logic [CNT_W-1:0] C_NOM      = CNT_W'(NOMINAL_HALF);
  localparam logic [CNT_W-1:0] C_MIN      = CNT_W'(MIN_HALF);
  localparam logic [CNT_W-1:0] C_MAX      = CNT_W'(MAX_HALF);
  localparam logic [CNT_W-1:0] C_KI_V     = CNT_W'(KI);
  localparam logic [CNT_W-1:0] C_KICK_POS = CNT_W'(KP);
  localparam logic [CNT_W-1:0] C_KICK_NEG = CNT_W'(-KP);
  localparam logic [Q_W-1:0]   C_LOCK_Q   = Q_W'(LOCK_EDGES);
  localparam logic [Q_W-1:0]   C_Q_ONE    = Q_W'(1);

  logic [CNT_W-1:0] r_hp;
  logic [CNT_W-1:0] r_kick;       // two's complement, only 0 / +KP / -KP
  logic             r_sat;
  logic             r_conflict;
  logic [Q_W-1:0]   r_quiet;
  lock_state_t      r_state;
  logic             r_lock;

  logic             w_fwd;
  logic             w_slow;
  logic             w_both;
  logic             w_event;
  logic             w_toggle;
  logic             w_signal;
  logic             w_rise;
  logic [CNT_W-1:0] w_hp_next;
  logic [CNT_W-1:0] w_limit;
  logic [Q_W-1:0]   w_quiet_inc;

  assign w_fwd       = forwarding_i & ~slowing_i;
  assign w_slow      = slowing_i & ~forwarding_i;
  assign w_both      = forwarding_i & slowing_i;
  assign w_event     = forwarding_i | slowing_i;
  assign w_rise      = w_toggle & ~w_signal;
  assign w_quiet_inc = r_quiet + C_Q_ONE;

  // Limit may wrap-add a negative kick; MIN_HALF > KP keeps it positive.
  assign w_limit = r_hp + r_kick;

  // Clamped integral step for a single, non-conflicting correction.
  always_comb begin
    w_hp_next = r_hp;
    if (w_fwd) begin
      w_hp_next = (r_hp <= C_MIN + C_KI_V) ? C_MIN : r_hp - C_KI_V;
    end else if (w_slow) begin
      w_hp_next = (r_hp >= C_MAX - C_KI_V) ? C_MAX : r_hp + C_KI_V;
    end
  end

  dco_counter #(
    .CNT_W (CNT_W)
  ) u_dco_counter (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .limit_i  (w_limit),
    .signal_o (w_signal),
    .toggle_o (w_toggle)
  );

  // Integral half-period, proportional kick and the saturation/conflict flags.
  // A new pulse outranks the toggle clear so a kick landing on the toggle
  // edge shapes the half that is just starting.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_hp       <= C_NOM;
      r_kick     <= '0;
      r_sat      <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      r_hp       <= w_hp_next;
      r_sat      <= (w_hp_next == C_MIN) || (w_hp_next == C_MAX);
      r_conflict <= w_both;
      if (w_fwd) begin
        r_kick <= C_KICK_NEG;
      end else if (w_slow) begin
        r_kick <= C_KICK_POS;
      end else if (w_toggle) begin
        r_kick <= '0;
      end
    end
  end

  // Lock FSM: quiet rising edges accumulate to LOCKED, any correction
  // (including a conflict) drops back to ACQ with the count cleared.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state <= ACQ;
      r_quiet <= '0;
      r_lock  <= 1'b0;
    end else if (w_event) begin
      r_state <= ACQ;
      r_quiet <= '0;
      r_lock  <= 1'b0;
    end else begin
      case (r_state)
        ACQ: begin
          if (w_rise) begin
            r_quiet <= w_quiet_inc;
            if (w_quiet_inc == C_LOCK_Q) begin
              r_state <= LOCKED;
              r_lock  <= 1'b1;
            end
          end
        end
        LOCKED: begin
          r_lock <= 1'b1;
        end
        default: begin
          r_state <= ACQ;
          r_lock  <= 1'b0;
        end
      endcase
    end
  end

  assign signal_o      = w_signal;
  assign half_period_o = r_hp;
  assign lock_o        = r_lock;
  assign sat_o         = r_sat;
  assign conflict_o    = r_conflict;

endmodule
`default_nettype wire

// File: doc/loop_filter_dco.md
LOOP_FILTER_DCO -- requirements
Module: loop_filter_dco

Interface
REQ-001 Parameter CNT_W, 16, width of half-period and counter values.
REQ-002 Parameter NOMINAL_HALF, 50, reset half-period in clk_i cycles.
REQ-003 Parameter MIN_HALF, 10, lower clamp of the half-period.
REQ-004 Parameter MAX_HALF, 200, upper clamp of the half-period.
REQ-005 Parameter KI, 1, integral step applied per correction pulse.
REQ-006 Parameter KP, 4, proportional one-shot kick, in cycles.
REQ-007 Parameter LOCK_EDGES, 16, count of quiet output rising edges required to declare lock.
REQ-008 clk_i  input  1  single system clock; all logic uses its rising edge.
REQ-009 reset_i  input  1  asynchronous, active-low reset.
REQ-010 forwarding_i  input  1  phase-detector pulse: feedback lags, speed up.
REQ-011 slowing_i  input  1  phase-detector pulse: feedback leads, slow down.
REQ-012 signal_o  output  1  generated square wave, fed back as the phase detector's B input.
REQ-013 half_period_o  output  CNT_W  current integral half-period.
REQ-014 lock_o  output  1  high while in the LOCKED state.
REQ-015 sat_o  output  1  high while the half-period equals MIN_HALF or MAX_HALF.
REQ-016 conflict_o  output  1  one-cycle pulse when both correction inputs are high together.

Function
REQ-017 Inputs are sampled at each clk_i rising edge; a one-cycle pulse is a single correction event.
REQ-018 forwarding_i alone: HP <= max(HP-KI, MIN_HALF), visible on half_period_o one cycle later.
REQ-019 slowing_i alone: HP <= min(HP+KI, MAX_HALF), visible on half_period_o one cycle later.
REQ-020 Both inputs high: HP and the kick are unchanged, conflict_o pulses next cycle, and the event counts as a correction for lock purposes.
REQ-021 Kick register: forwarding sets it to -KP, slowing sets it to +KP; the latest pulse overwrites it; it clears when signal_o toggles.
REQ-022 Phase counter cnt runs 0 upward; limit = HP + kick, evaluated combinationally each cycle.
REQ-023 When cnt+1 >= limit, signal_o toggles, cnt <= 0, and the kick clears, all in the same edge; a cnt already past a shortened limit toggles at the next edge.
REQ-024 A half-period is therefore never shorter than MIN_HALF-KP cycles; parameters SHALL satisfy MIN_HALF > KP, MAX_HALF+KP < 2**CNT_W, and MIN_HALF <= NOMINAL_HALF <= MAX_HALF.
REQ-025 An HP change mid-half takes effect through limit in the same half.
REQ-026 Lock state machine: ACQ and LOCKED. Any correction event resets the quiet counter and enters ACQ. Each signal_o rising edge without an event increments the counter. When the counter reaches LOCK_EDGES, the FSM enters LOCKED; the counter saturates.
REQ-027 A correction event and a rising edge in the same cycle count as a correction; the quiet counter goes to 0.
REQ-028 sat_o and lock_o are registered and derived from the updated state.

Reset
REQ-029 reset_i low asynchronously forces HP=NOMINAL_HALF, kick=0, cnt=0, signal_o=0, quiet counter=0, FSM=ACQ, lock_o=0, sat_o=0, conflict_o=0.
REQ-030 Reset mid-half aborts the half; after release, the first toggle occurs NOMINAL_HALF cycles after the first active edge.

Structure
REQ-031 Package pll_pkg holds the lock-state enum (ACQ, LOCKED) and default parameter constants, shared with the phase detector bench.
REQ-032 Sub-module dco_counter holds cnt, the limit compare and the signal_o toggle; loop_filter_dco holds HP, the kick, the FSM and the flags.

Verification
REQ-033 Reset, no pulses -> signal_o toggles every 50 cycles, lock_o rises at the 16th rising edge, half_period_o=50.
REQ-034 One forwarding pulse mid-half -> half_period_o=49 next cycle, and that half lasts 45 cycles (49-4); the following halves last 49.
REQ-035 200 consecutive slowing pulses -> half_period_o stops at 200, sat_o=1, and lock_o=0 throughout.
REQ-036 forwarding_i and slowing_i high together for one cycle -> conflict_o pulses once, HP unchanged, quiet counter cleared, lock_o drops.
REQ-037 Forwarding pulse at cnt=47 with HP=50 -> limit 45, so toggle at the next edge, then a normal 49-cycle half.
REQ-038 reset_i asserted mid-half, between clock edges -> all outputs reach reset values immediately without a clock edge.
